md5_step_feeder: RTL and testbench



---
 rtl/md5_step_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_md5_step_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_step_feeder.sv
// md5_step_feeder
//
// Buffers one 512-bit MD5 message block (sixteen 32-bit words X[0..15]) and
// then presents the 64 per-step operand sets (X[k], T[i], s, i) to the
// downstream round-step datapath over a valid/ready stream.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    input word valid
//   in_ready    feeder accepts a word this cycle (never depends on in_valid)
//   in_word     message word; the k-th accepted word of a block is X[k]
//   step_valid  step operands valid (registered)
//   step_ready  consumer accepts the step this cycle
//   step_msg    X[k] for the current step
//   step_t      T[i] additive constant
//   step_shift  left-rotate amount s
//   step_idx    step number i, 0..63
//   step_round  i/16
//   step_first  high when i == 0
//   step_last   high when i == 63
//
// Build option:
//   MD5_DOUBLE_BUF_EN  adds a shadow 16-word buffer that fills while the active
//                      block is being issued, so back-to-back blocks run with
//                      no load gap. Undefined: single buffer, in_ready is low
//                      for the whole issue phase.

module md5_step_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        step_valid,
  input  logic        step_ready,
  output logic [31:0] step_msg,
  output logic [31:0] step_t,
  output logic [4:0]  step_shift,
  output logic [5:0]  step_idx,
  output logic [1:0]  step_round,
  output logic        step_first,
  output logic        step_last
);

  typedef enum logic {S_LOAD, S_ISSUE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wcnt;

  // Message index k for step i; all arithmetic is naturally mod 16 in 4 bits.
  function automatic logic [3:0] msg_index(input logic [5:0] i);
    logic [3:0] j;
    logic [3:0] k;
    j = i[3:0];
    case (i[5:4])
      2'd0:    k = j;
      2'd1:    k = (j << 2) + j + 4'd1;   // 5j+1
      2'd2:    k = (j << 1) + j + 4'd5;   // 3j+5
      default: k = (j << 3) - j;          // 7j
    endcase
    return k;
  endfunction

  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'b00_00: s = 5'd7;
      4'b00_01: s = 5'd12;
      4'b00_10: s = 5'd17;
      4'b00_11: s = 5'd22;
      4'b01_00: s = 5'd5;
      4'b01_01: s = 5'd9;
      4'b01_10: s = 5'd14;
      4'b01_11: s = 5'd20;
      4'b10_00: s = 5'd4;
      4'b10_01: s = 5'd11;
      4'b10_10: s = 5'd16;
      4'b10_11: s = 5'd23;
      4'b11_00: s = 5'd6;
      4'b11_01: s = 5'd10;
      4'b11_10: s = 5'd15;
      default:  s = 5'd21;
    endcase
    return s;
  endfunction

  // T[i] = floor(2^32 * |sin(i+1)|)
  function automatic logic [31:0] t_rom(input logic [5:0] i);
    logic [31:0] t;
    case (i)
      6'd0:  t = 32'hd76aa478;  6'd1:  t = 32'he8c7b756;  6'd2:  t = 32'h242070db;  6'd3:  t = 32'hc1bdceee;
      6'd4:  t = 32'hf57c0faf;  6'd5:  t = 32'h4787c62a;  6'd6:  t = 32'ha8304613;  6'd7:  t = 32'hfd469501;
      6'd8:  t = 32'h698098d8;  6'd9:  t = 32'h8b44f7af;  6'd10: t = 32'hffff5bb1;  6'd11: t = 32'h895cd7be;
      6'd12: t = 32'h6b901122;  6'd13: t = 32'hfd987193;  6'd14: t = 32'ha679438e;  6'd15: t = 32'h49b40821;
      6'd16: t = 32'hf61e2562;  6'd17: t = 32'hc040b340;  6'd18: t = 32'h265e5a51;  6'd19: t = 32'he9b6c7aa;
      6'd20: t = 32'hd62f105d;  6'd21: t = 32'h02441453;  6'd22: t = 32'hd8a1e681;  6'd23: t = 32'he7d3fbc8;
      6'd24: t = 32'h21e1cde6;  6'd25: t = 32'hc33707d6;  6'd26: t = 32'hf4d50d87;  6'd27: t = 32'h455a14ed;
      6'd28: t = 32'ha9e3e905;  6'd29: t = 32'hfcefa3f8;  6'd30: t = 32'h676f02d9;  6'd31: t = 32'h8d2a4c8a;
      6'd32: t = 32'hfffa3942;  6'd33: t = 32'h8771f681;  6'd34: t = 32'h6d9d6122;  6'd35: t = 32'hfde5380c;
      6'd36: t = 32'ha4beea44;  6'd37: t = 32'h4bdecfa9;  6'd38: t = 32'hf6bb4b60;  6'd39: t = 32'hbebfbc70;
      6'd40: t = 32'h289b7ec6;  6'd41: t = 32'heaa127fa;  6'd42: t = 32'hd4ef3085;  6'd43: t = 32'h04881d05;
      6'd44: t = 32'hd9d4d039;  6'd45: t = 32'he6db99e5;  6'd46: t = 32'h1fa27cf8;  6'd47: t = 32'hc4ac5665;
      6'd48: t = 32'hf4292244;  6'd49: t = 32'h432aff97;  6'd50: t = 32'hab9423a7;  6'd51: t = 32'hfc93a039;
      6'd52: t = 32'h655b59c3;  6'd53: t = 32'h8f0ccc92;  6'd54: t = 32'hffeff47d;  6'd55: t = 32'h85845dd1;
      6'd56: t = 32'h6fa87e4f;  6'd57: t = 32'hfe2ce6e0;  6'd58: t = 32'ha3014314;  6'd59: t = 32'h4e0811a1;
      6'd60: t = 32'hf7537e82;  6'd61: t = 32'hbd3af235;  6'd62: t = 32'h2ad7d2bb;  default: t = 32'heb86d391;
    endcase
    return t;
  endfunction

  logic        w_in_hs;
  logic        w_step_hs;
  logic        w_last_hs;
  logic        w_start;
  logic        w_adv;
  logic        w_wrap;
  logic        w_load_ops;
  logic [5:0]  w_nxt_idx;
  logic [3:0]  w_k;
  logic [31:0] w_rd_word;

  assign w_in_hs   = in_valid & in_ready;
  assign w_step_hs = step_valid & step_ready;
  assign w_last_hs = w_step_hs & (step_idx == 6'd63);
  // The 16th word is still in flight when step 0 is prepared, but step 0
  // only needs X[0], which was stored fifteen words earlier.
  assign w_start   = (r_state == S_LOAD) & w_in_hs & (r_wcnt == 4'd15);
  assign w_adv     = w_step_hs & (step_idx != 6'd63);
  assign w_nxt_idx = w_adv ? (step_idx + 6'd1) : 6'd0;
  assign w_k       = msg_index(w_nxt_idx);

`ifdef MD5_DOUBLE_BUF_EN
  logic [31:0] r_buf [2][16];
  logic        r_act;       // buffer being issued (or filled in LOAD)
  logic [4:0]  r_shw_cnt;   // words held in the shadow buffer, 0..16
  logic        w_shw_acc;
  logic [4:0]  w_shw_cnt_nxt;
  logic        w_rd_sel;

  assign w_shw_acc     = (r_state == S_ISSUE) & w_in_hs;
  assign w_shw_cnt_nxt = r_shw_cnt + {4'd0, w_shw_acc};
  // A word landing on the same cycle as the step-63 handshake still counts.
  assign w_wrap        = w_last_hs & (w_shw_cnt_nxt == 5'd16);
  assign w_rd_sel      = w_wrap ? ~r_act : r_act;
  assign w_rd_word     = r_buf[w_rd_sel][w_k];

  always_comb begin
    in_ready = 1'b1;
    if (r_state == S_ISSUE) in_ready = (r_shw_cnt != 5'd16);
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      if (r_state == S_LOAD) r_buf[r_act][r_wcnt] <= in_word;
      else                   r_buf[~r_act][r_shw_cnt[3:0]] <= in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act     <= 1'b0;
      r_shw_cnt <= 5'd0;
    end else if (w_last_hs) begin
      // Shadow always becomes active: either it is issued at once or it
      // keeps filling in LOAD from where it stopped.
      r_act     <= ~r_act;
      r_shw_cnt <= 5'd0;
    end else if (w_shw_acc) begin
      r_shw_cnt <= w_shw_cnt_nxt;
    end
  end
`else
  logic [31:0] r_buf [16];

  assign w_wrap    = 1'b0;
  assign w_rd_word = r_buf[w_k];

  always_comb begin
    in_ready = (r_state == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_wcnt] <= in_word;
  end
`endif

  assign w_load_ops = w_start | w_adv | w_wrap;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last_hs && !w_wrap) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_LOAD) && w_in_hs) begin
        r_wcnt <= r_wcnt + 4'd1;
`ifdef MD5_DOUBLE_BUF_EN
      end else if (w_last_hs && !w_wrap) begin
        // Resume filling the partially loaded shadow buffer.
        r_wcnt <= w_shw_cnt_nxt[3:0];
`endif
      end
    end
  end

  // Registered step operand stage
  always_ff @(posedge clk) begin
    if (rst) begin
      step_valid <= 1'b0;
      step_msg   <= 32'd0;
      step_t     <= 32'd0;
      step_shift <= 5'd0;
      step_idx   <= 6'd0;
      step_round <= 2'd0;
      step_first <= 1'b0;
      step_last  <= 1'b0;
    end else if (w_load_ops) begin
      step_valid <= 1'b1;
      step_msg   <= w_rd_word;
      step_t     <= t_rom(w_nxt_idx);
      step_shift <= shift_amt(w_nxt_idx);
      step_idx   <= w_nxt_idx;
      step_round <= w_nxt_idx[5:4];
      step_first <= (w_nxt_idx == 6'd0);
      step_last  <= (w_nxt_idx == 6'd63);
    end else if (w_step_hs) begin
      step_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md5_step_feeder.sv
module tb_md5_step_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        step_valid;
  logic        step_ready;
  logic [31:0] step_msg;
  logic [31:0] step_t;
  logic [4:0]  step_shift;
  logic [5:0]  step_idx;
  logic [1:0]  step_round;
  logic        step_first;
  logic        step_last;

  int n_cmp = 0;
  int n_bad = 0;

  md5_step_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_msg   (step_msg),
    .step_t     (step_t),
    .step_shift (step_shift),
    .step_idx   (step_idx),
    .step_round (step_round),
    .step_first (step_first),
    .step_last  (step_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int kfun(input int i);
    int j;
    j = i % 16;
    case (i / 16)
      0:       return j;
      1:       return (5 * j + 1) % 16;
      2:       return (3 * j + 5) % 16;
      default: return (7 * j) % 16;
    endcase
  endfunction

  function automatic int sfun(input int i);
    case (i / 16)
      0:       case (i % 4) 0: return 7; 1: return 12; 2: return 17; default: return 22; endcase
      1:       case (i % 4) 0: return 5; 1: return 9;  2: return 14; default: return 20; endcase
      2:       case (i % 4) 0: return 4; 1: return 11; 2: return 16; default: return 23; endcase
      default: case (i % 4) 0: return 6; 1: return 10; 2: return 15; default: return 21; endcase
    endcase
  endfunction

  // Load 16 words base+k, idling 'gap' cycles between words.
  task automatic load_block(input logic [31:0] base, input int gap);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_word  = base + k;
      chk("load_in_ready", in_ready, 1);
      if (k == 15) chk("pre_start_valid", step_valid, 0);
      tick();
      in_valid = 1'b0;
      if (k < 15) for (int g = 0; g < gap; g++) tick();
    end
    chk("start_valid", step_valid, 1);
    chk("start_idx", step_idx, 0);
    chk("start_first", step_first, 1);
    chk("start_msg", step_msg, base);
  endtask

  // Drive the issue phase. mode 0: ready always 1; mode 1: ready 1,0,0,1.
  // Stops without clocking when step 'stop_at' is presented (64 = run out).
  // With feed=1 the next block base2+k is offered on in_word meanwhile.
  task automatic run_issue(input logic [31:0] base, input int mode, input int stop_at,
                           input bit feed, input logic [31:0] base2);
    int exp_i = 0;
    int vcyc = 0;
    int cyc = 0;
    int fed = 0;
    bit stalled = 0;
    bit done = 0;
    logic [31:0] h_msg, h_t;
    logic [4:0]  h_sh;
    while (!done && cyc < 1000) begin
      bit acc;
      bit stop;
      stop = 0;
      step_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid   = feed && (fed < 16);
      in_word    = base2 + fed;
      if (stalled) begin
        chk("hold_valid", step_valid, 1);
        chk("hold_msg", step_msg, h_msg);
        chk("hold_t", step_t, h_t);
        chk("hold_shift", step_shift, h_sh);
        stalled = 0;
      end
      if (step_valid) begin
        vcyc++;
        chk("idx", step_idx, exp_i);
        chk("msg", step_msg, base + kfun(exp_i));
        chk("shift", step_shift, sfun(exp_i));
        chk("round", step_round, exp_i / 16);
        chk("first", step_first, exp_i == 0);
        chk("last", step_last, exp_i == 63);
`ifndef MD5_DOUBLE_BUF_EN
        chk("issue_in_ready", in_ready, 0);
`endif
        case (exp_i)
          0:  chk("t0",  step_t, 32'hd76aa478);
          15: chk("t15", step_t, 32'h49b40821);
          16: chk("t16", step_t, 32'hf61e2562);
          32: chk("t32", step_t, 32'hfffa3942);
          48: chk("t48", step_t, 32'hf4292244);
          63: chk("t63", step_t, 32'heb86d391);
          default: ;
        endcase
        if (exp_i == stop_at) stop = 1;
        else if (step_ready) exp_i++;
        else begin
          stalled = 1;
          h_msg = step_msg;
          h_t   = step_t;
          h_sh  = step_shift;
        end
      end
      acc = in_valid && in_ready;
      if (stop) done = 1;
      else begin
        tick();
        cyc++;
        if (acc) fed++;
        if (exp_i == 64) done = 1;
      end
    end
    in_valid   = 1'b0;
    step_ready = 1'b0;
    if (!done) chk("issue_timeout", exp_i, 64);
    if (stop_at == 64) begin
      chk("handshakes", exp_i, 64);
      if (mode == 0) chk("valid_cycles", vcyc, 64);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_word    = 32'd0;
    step_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_msg", step_msg, 0);
    chk("rst_t", step_t, 0);
    chk("rst_shift", step_shift, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_round", step_round, 0);
    chk("rst_first", step_first, 0);
    chk("rst_last", step_last, 0);

    // Full block, consumer always ready
    load_block(32'h10000000, 0);
    run_issue(32'h10000000, 0, 64, 1'b0, 32'd0);
    chk("end_in_ready", in_ready, 1);
    chk("end_step_valid", step_valid, 0);

    // Same block with a stalling consumer
    load_block(32'h10000000, 0);
    run_issue(32'h10000000, 1, 64, 1'b0, 32'd0);
    chk("stall_end_in_ready", in_ready, 1);
    chk("stall_end_valid", step_valid, 0);

    // Sparse input: a word every third cycle
    load_block(32'h50000000, 2);
    run_issue(32'h50000000, 0, 64, 1'b0, 32'd0);
    chk("sparse_end_in_ready", in_ready, 1);

    // Reset after word 9
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_word  = 32'hdead0000 + k;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midload_rst_in_ready", in_ready, 1);
    chk("midload_rst_valid", step_valid, 0);
    load_block(32'h30000000, 0);

    // Reset while step 20 is presented
    run_issue(32'h30000000, 0, 20, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midissue_rst_valid", step_valid, 0);
    chk("midissue_rst_in_ready", in_ready, 1);
    chk("midissue_rst_idx", step_idx, 0);

    // Recovery after reset
    load_block(32'h40000000, 0);
    run_issue(32'h40000000, 0, 64, 1'b0, 32'd0);
    chk("recover_in_ready", in_ready, 1);

`ifdef MD5_DOUBLE_BUF_EN
    // Back-to-back blocks through the shadow buffer
    load_block(32'h10000000, 0);
    run_issue(32'h10000000, 0, 64, 1'b1, 32'h20000000);
    chk("b2b_valid", step_valid, 1);
    chk("b2b_idx", step_idx, 0);
    chk("b2b_msg", step_msg, 32'h20000000);
    chk("b2b_first", step_first, 1);
    chk("b2b_in_ready", in_ready, 1);
    run_issue(32'h20000000, 0, 64, 1'b0, 32'd0);
    chk("b2b_end_valid", step_valid, 0);
    chk("b2b_end_in_ready", in_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
